// File: rtl/l2_arbiter.sv
// Two-master arbiter between the split L1 caches and the unified L2 CPU-side port.
// One transaction in flight; ties are broken round-robin against the previous owner.
module l2_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_read,
   input  logic [ADDR_WIDTH-1:0] icache_address,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,
   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [ADDR_WIDTH-1:0] dcache_address,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic [LINE_WIDTH-1:0] l2_rdata,
   input  logic                  l2_resp
);

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(31);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                  state_reg, state_next;
   logic                    owner_d_reg;
   logic                    last_d_reg;
   logic                    write_reg;
   logic [ADDR_WIDTH-1:0]   addr_reg;
   logic [LINE_WIDTH-1:0]   wdata_reg;
   logic [LINE_WIDTH-1:0]   irdata_reg;
   logic [LINE_WIDTH-1:0]   drdata_reg;

   logic                    i_req, d_req, grant_d, grant_write;
   logic [ADDR_WIDTH-1:0]   grant_addr;

   // D wins when alone, or on a tie when I was the previous owner.
   always_comb begin
      i_req       = icache_read;
      d_req       = dcache_read | dcache_write;
      grant_d     = d_req & (~i_req | ~last_d_reg);
      grant_write = grant_d & dcache_write;
      grant_addr  = (grant_d ? dcache_address : icache_address) & LINE_MASK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_req || d_req) state_next = BUSY;
         BUSY:    if (l2_resp) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_d_reg <= 1'b0;
         last_d_reg  <= 1'b0;
         write_reg   <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         irdata_reg  <= '0;
         drdata_reg  <= '0;
      end else begin
         if (state_reg == IDLE && (i_req || d_req)) begin
            owner_d_reg <= grant_d;
            last_d_reg  <= grant_d;
            write_reg   <= grant_write;
            addr_reg    <= grant_addr;
            wdata_reg   <= grant_write ? dcache_wdata : '0;
         end
         // Write completions leave the owner's read line untouched.
         if (state_reg == BUSY && l2_resp && !write_reg) begin
            if (owner_d_reg) begin
               drdata_reg <= l2_rdata;
            end else begin
               irdata_reg <= l2_rdata;
            end
         end
      end
   end

   always_comb begin
      l2_read      = (state_reg == BUSY) & ~write_reg;
      l2_write     = (state_reg == BUSY) & write_reg;
      l2_address   = addr_reg;
      l2_wdata     = wdata_reg;
      icache_resp  = (state_reg == RESP) & ~owner_d_reg;
      dcache_resp  = (state_reg == RESP) & owner_d_reg;
      icache_rdata = irdata_reg;
      dcache_rdata = drdata_reg;
   end

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: acts as both L1 caches and the L2, predicting owner,
// address, op, latency and returned lines from the arbitration rules.
module tb_l2_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          icache_read;
   logic [AW-1:0] icache_address;
   logic [LW-1:0] icache_rdata;
   logic          icache_resp;
   logic          dcache_read;
   logic          dcache_write;
   logic [AW-1:0] dcache_address;
   logic [LW-1:0] dcache_wdata;
   logic [LW-1:0] dcache_rdata;
   logic          dcache_resp;
   logic          l2_read;
   logic          l2_write;
   logic [AW-1:0] l2_address;
   logic [LW-1:0] l2_wdata;
   logic [LW-1:0] l2_rdata;
   logic          l2_resp;

   int total = 0;
   int bad   = 0;

   // Reference state: previous owner and the last line each master received.
   bit            m_last_d;
   logic [LW-1:0] m_irdata;
   logic [LW-1:0] m_drdata;

   l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .icache_read(icache_read), .icache_address(icache_address),
      .icache_rdata(icache_rdata), .icache_resp(icache_resp),
      .dcache_read(dcache_read), .dcache_write(dcache_write),
      .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
      .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_l2_read"}, l2_read, 1'b0);
      chk({tag, "_l2_write"}, l2_write, 1'b0);
      chk({tag, "_icache_resp"}, icache_resp, 1'b0);
      chk({tag, "_dcache_resp"}, dcache_resp, 1'b0);
      chk({tag, "_icache_rdata"}, icache_rdata, m_irdata);
      chk({tag, "_dcache_rdata"}, dcache_rdata, m_drdata);
   endtask

   task automatic model_reset();
      m_last_d = 1'b0;
      m_irdata = '0;
      m_drdata = '0;
   endtask

   task automatic clear_inputs();
      icache_read    = 1'b0;
      icache_address = '0;
      dcache_read    = 1'b0;
      dcache_write   = 1'b0;
      dcache_address = '0;
      dcache_wdata   = '0;
      l2_rdata       = '0;
      l2_resp        = 1'b0;
   endtask

   // Called in an IDLE cycle with requests already applied; returns in the following IDLE cycle.
   task automatic serve(input int delay, input bit inject, input bit junk, input logic [LW-1:0] data);
      bit            exp_d, exp_w;
      logic [AW-1:0] exp_a;
      logic [LW-1:0] exp_wd;
      exp_d  = (dcache_read || dcache_write) && (!icache_read || !m_last_d);
      exp_w  = exp_d && dcache_write;
      exp_a  = (exp_d ? dcache_address : icache_address) & 32'hFFFF_FFE0;
      exp_wd = exp_w ? dcache_wdata : '0;
      m_last_d = exp_d;
      step();
      for (int k = 1; k <= delay; k++) begin
         chk("busy_l2_read", l2_read, !exp_w);
         chk("busy_l2_write", l2_write, exp_w);
         chk("busy_l2_address", l2_address, exp_a);
         chk("busy_l2_wdata", l2_wdata, exp_wd);
         chk("busy_icache_resp", icache_resp, 1'b0);
         chk("busy_dcache_resp", dcache_resp, 1'b0);
         if (inject && k == 1) begin
            if (exp_d && !icache_read) begin
               icache_read    = 1'b1;
               icache_address = $urandom;
            end else if (!exp_d && !dcache_read && !dcache_write) begin
               dcache_read    = 1'b1;
               dcache_write   = 1'($urandom_range(0, 1));
               dcache_address = $urandom;
               dcache_wdata   = rand_line();
            end
         end
         if (k == delay) begin
            l2_rdata = data;
            l2_resp  = 1'b1;
         end
         step();
      end
      // RESP cycle
      l2_resp = junk;
      if (junk) l2_rdata = rand_line();
      if (!exp_w) begin
         if (exp_d) m_drdata = data;
         else       m_irdata = data;
      end
      chk("resp_icache_resp", icache_resp, !exp_d);
      chk("resp_dcache_resp", dcache_resp, exp_d);
      chk("resp_l2_read", l2_read, 1'b0);
      chk("resp_l2_write", l2_write, 1'b0);
      chk("resp_icache_rdata", icache_rdata, m_irdata);
      chk("resp_dcache_rdata", dcache_rdata, m_drdata);
      if (exp_d) begin
         dcache_read  = 1'b0;
         dcache_write = 1'b0;
      end else begin
         icache_read = 1'b0;
      end
      step();
      l2_resp = 1'b0;
      check_quiet("idle");
   endtask

   task automatic idle_cycle(input bit junk);
      l2_resp = junk;
      if (junk) l2_rdata = rand_line();
      step();
      l2_resp = 1'b0;
      check_quiet("noreq");
   endtask

   initial begin
      int r;
      rst = 1'b1;
      clear_inputs();
      model_reset();
      step();
      step();
      check_quiet("reset");
      chk("reset_l2_address", l2_address, '0);
      chk("reset_l2_wdata", l2_wdata, '0);
      rst = 1'b0;
      step();

      // Single I read, non-aligned address, L2 answers after 3 cycles
      icache_read    = 1'b1;
      icache_address = 32'h0000_1234;
      serve(3, 1'b0, 1'b0, {32{8'hAB}});

      // D write-back
      dcache_write   = 1'b1;
      dcache_address = 32'h8000_0040;
      dcache_wdata   = {32{8'h5A}};
      serve(2, 1'b0, 1'b0, rand_line());

      // Fresh reset, then both masters requesting continuously: D, I, D, I
      rst = 1'b1;
      clear_inputs();
      model_reset();
      step();
      rst = 1'b0;
      check_quiet("rst2");
      step();
      for (int n = 0; n < 4; n++) begin
         if (!icache_read) begin
            icache_read    = 1'b1;
            icache_address = 32'h0000_1000 + 32'(n * 64) + 32'd7;
         end
         if (!dcache_read) begin
            dcache_read    = 1'b1;
            dcache_address = 32'h4000_0000 + 32'(n * 64) + 32'd3;
         end
         serve(1 + n, 1'b0, 1'b0, rand_line());
      end
      serve(1, 1'b0, 1'b0, rand_line());

      // Owner isolation: I arrives mid-BUSY on a D read and waits for it
      dcache_read    = 1'b1;
      dcache_address = 32'h2222_2222;
      serve(3, 1'b1, 1'b0, rand_line());
      serve(2, 1'b0, 1'b0, rand_line());

      // Zero-wait L2 with a back-to-back D read; l2_resp during RESP and IDLE ignored
      dcache_read    = 1'b1;
      dcache_address = 32'h0000_0100;
      serve(1, 1'b0, 1'b1, rand_line());
      dcache_read    = 1'b1;
      dcache_address = 32'h0000_0120;
      serve(1, 1'b0, 1'b0, rand_line());
      idle_cycle(1'b1);

      // Reset in the middle of BUSY aborts with no response
      dcache_read    = 1'b1;
      dcache_address = 32'h0BAD_0000;
      step();
      chk("abort_busy_l2_read", l2_read, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_async_l2_read", l2_read, 1'b0);
      chk("abort_async_l2_address", l2_address, '0);
      clear_inputs();
      model_reset();
      step();
      step();
      rst = 1'b0;
      check_quiet("abort");
      step();
      check_quiet("abort_after");
      icache_read    = 1'b1;
      icache_address = 32'h0000_0A5F;
      serve(2, 1'b0, 1'b0, rand_line());

      // Randomized traffic
      for (int it = 0; it < 80; it++) begin
         if (!icache_read && $urandom_range(0, 2) != 0) begin
            icache_read    = 1'b1;
            icache_address = $urandom;
         end
         if (!dcache_read && !dcache_write && $urandom_range(0, 2) != 0) begin
            r              = int'($urandom_range(0, 2));
            dcache_read    = (r != 1);
            dcache_write   = (r != 0);
            dcache_address = $urandom;
            dcache_wdata   = rand_line();
         end
         if (icache_read || dcache_read || dcache_write) begin
            serve(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rand_line());
         end else begin
            idle_cycle(1'($urandom_range(0, 1)));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
